// File: rtl/seq_div_unit.sv
// seq_div_unit: multi-cycle restoring divider, signed/unsigned, RADIX_BITS quotient bits per cycle
module seq_div_unit #(
    parameter int WIDTH      = 8,
    parameter int RADIX_BITS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signedMode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             divByZero
);
    localparam int K  = WIDTH / RADIX_BITS;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    if (RADIX_BITS < 1 || WIDTH < 2 || (WIDTH % RADIX_BITS) != 0) begin : g_bad_params
        $error("seq_div_unit: RADIX_BITS must be >= 1 and divide WIDTH, WIDTH must be >= 2");
    end

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state_q, state_d;
    logic             sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;
    logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d, prem_q, prem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
    logic             done_q, done_d, dzo_q, dzo_d;
    logic [WIDTH:0]   step_sh, step_diff;
    logic [WIDTH-1:0] step_r, step_d;

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign divByZero = dzo_q;

    // RADIX_BITS chained restoring steps; dvd shifts out dividend bits and shifts in quotient bits
    always_comb begin
        step_r    = prem_q;
        step_d    = dvd_q;
        step_sh   = '0;
        step_diff = '0;
        for (int i = 0; i < RADIX_BITS; i++) begin
            step_sh   = {step_r, step_d[WIDTH-1]};
            step_diff = step_sh - {1'b0, dvs_q};
            step_r    = step_diff[WIDTH] ? step_sh[WIDTH-1:0] : step_diff[WIDTH-1:0];
            step_d    = {step_d[WIDTH-2:0], ~step_diff[WIDTH]};
        end
    end

    // next-state and datapath updates
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        dz_d    = dz_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dzo_d   = dzo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                sa_d    = signedMode & dividend[WIDTH-1];
                sb_d    = signedMode & divisor[WIDTH-1];
                dz_d    = (divisor == '0);
                dvs_d   = sb_d ? -divisor : divisor;
                // on divide-by-zero keep the raw dividend: it is returned as the remainder
                dvd_d   = (dz_d || !sa_d) ? dividend : -dividend;
                prem_d  = '0;
                cnt_d   = '0;
                state_d = dz_d ? FIX : RUN;
            end
            RUN: begin
                prem_d  = step_r;
                dvd_d   = step_d;
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(K - 1)) ? FIX : RUN;
            end
            FIX: begin
                quo_d   = dz_q ? '1 : ((sa_q ^ sb_q) ? -dvd_q : dvd_q);
                rem_d   = dz_q ? dvd_q : (sa_q ? -prem_q : prem_q);
                dzo_d   = dz_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // operand, iteration and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
            dz_q   <= 1'b0;
            dvd_q  <= '0;
            dvs_q  <= '0;
            prem_q <= '0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dzo_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sa_q   <= sa_d;
            sb_q   <= sb_d;
            dz_q   <= dz_d;
            dvd_q  <= dvd_d;
            dvs_q  <= dvs_d;
            prem_q <= prem_d;
            cnt_q  <= cnt_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dzo_q  <= dzo_d;
            done_q <= done_d;
        end
    end
endmodule
